// File: rtl/proc_pkg.sv
// Shared widths, opcodes and event helpers for the processor hierarchy.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package proc_pkg;

    localparam int CNT_W_DEF = 32;
    localparam int WORD_W    = 16;
    localparam int REG_IDX_W = 3;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_LW   = 4'h3;
    localparam logic [3:0] OP_SW   = 4'h4;
    localparam logic [3:0] OP_HALT = 4'hF;

    // An instruction retires when it commits a register, commits a store, or is HALT.
    function automatic logic retireEvent(input logic halt, input logic regWrite, input logic memWrite);
        return halt | regWrite | memWrite;
    endfunction

    function automatic logic [WORD_W-1:0] encode(input logic [3:0] op, input logic [REG_IDX_W-1:0] rd,
                                                 input logic [REG_IDX_W-1:0] rs, input logic [5:0] imm);
        return {op, rd, rs, imm};
    endfunction

endpackage

// File: rtl/proc.sv
// Small two-stage 16-bit core with single-line instruction and data cache tags.
// Latency: fetch -> decode register -> execute/commit; a tag miss costs one stall cycle.
// Backpressure: data-tag miss stalls the whole pipe; instruction-tag miss injects a NOP bubble.
module proc
    import proc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    output logic [WORD_W-1:0]    pc,
    output logic [WORD_W-1:0]    inst,
    output logic                 regWrite,
    output logic [REG_IDX_W-1:0] writeRegister,
    output logic [WORD_W-1:0]    writeData,
    output logic                 memRead,
    output logic                 memWrite,
    output logic [WORD_W-1:0]    memAddress,
    output logic [WORD_W-1:0]    memDataIn,
    output logic [WORD_W-1:0]    memDataOut,
    output logic                 icacheReq,
    output logic                 icacheHit,
    output logic                 dcacheReq,
    output logic                 dcacheHit,
    output logic                 halt
);

    logic [WORD_W-1:0]    pcQ, ifId, romWord, imm, rsVal, rtVal, rdVal, aluRes, loadVal;
    logic [WORD_W-1:0]    regFile [0:7];
    logic [WORD_W-1:0]    dataMem [0:7];
    logic [WORD_W-4:0]    iTag, dTag;
    logic                 iTagVld, dTagVld;
    logic [3:0]           op;
    logic [REG_IDX_W-1:0] rd, rs, rt;
    logic                 isLoad, isStore, isHalt, writesReg, dStall;

    // Program image is indexed by the low PC bits, so the program loops forever.
    always_comb begin
        case (pcQ[3:0])
            4'd0:    romWord = encode(OP_ADDI, 3'd1, 3'd0, 6'd5);
            4'd1:    romWord = encode(OP_ADDI, 3'd2, 3'd0, 6'd9);
            4'd2:    romWord = encode(OP_ADD,  3'd3, 3'd1, {3'd2, 3'd0});
            4'd3:    romWord = encode(OP_SW,   3'd3, 3'd0, 6'd2);
            4'd4:    romWord = encode(OP_LW,   3'd4, 3'd0, 6'd2);
            4'd5:    romWord = encode(OP_ADDI, 3'd1, 3'd1, 6'd1);
            4'd6:    romWord = encode(OP_SW,   3'd1, 3'd0, 6'd12);
            4'd7:    romWord = encode(OP_LW,   3'd5, 3'd0, 6'd12);
            4'd8:    romWord = encode(OP_ADD,  3'd6, 3'd4, {3'd5, 3'd0});
            4'd10:   romWord = encode(OP_HALT, 3'd0, 3'd0, 6'd0);
            4'd11:   romWord = encode(OP_ADDI, 3'd7, 3'd7, 6'd1);
            4'd12:   romWord = encode(OP_SW,   3'd7, 3'd0, 6'd4);
            default: romWord = encode(OP_NOP,  3'd0, 3'd0, 6'd0);
        endcase
    end

    assign op     = ifId[15:12];
    assign rd     = ifId[11:9];
    assign rs     = ifId[8:6];
    assign rt     = ifId[5:3];
    assign imm    = {{(WORD_W-6){ifId[5]}}, ifId[5:0]};
    assign rsVal  = (rs == '0) ? '0 : regFile[rs];
    assign rtVal  = (rt == '0) ? '0 : regFile[rt];
    assign rdVal  = (rd == '0) ? '0 : regFile[rd];
    assign aluRes = (op == OP_ADD) ? rsVal + rtVal : rsVal + imm;
    assign loadVal = dataMem[aluRes[2:0]];

    assign isLoad    = (op == OP_LW);
    assign isStore   = (op == OP_SW);
    assign isHalt    = (op == OP_HALT);
    assign writesReg = (op == OP_ADDI) || (op == OP_ADD) || (op == OP_LW);

    assign dcacheReq = rst && (isLoad || isStore);
    assign dcacheHit = dTagVld && (dTag == aluRes[WORD_W-1:3]);
    assign dStall    = dcacheReq && !dcacheHit;
    assign icacheReq = rst && !dStall;
    assign icacheHit = iTagVld && (iTag == pcQ[WORD_W-1:3]);

    // Commit-stage strobes are qualified by the data stall so a retried access counts once.
    assign regWrite      = rst && writesReg && !dStall;
    assign memRead       = rst && isLoad && !dStall;
    assign memWrite      = rst && isStore && !dStall;
    assign halt          = rst && isHalt;
    assign writeRegister = rd;
    assign writeData     = isLoad ? loadVal : aluRes;
    assign memAddress    = aluRes;
    assign memDataIn     = rdVal;
    assign memDataOut    = loadVal;
    assign pc            = pcQ;
    assign inst          = ifId;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pcQ     <= '0;
            ifId    <= encode(OP_NOP, 3'd0, 3'd0, 6'd0);
            iTag    <= '0;
            iTagVld <= 1'b0;
            dTag    <= '0;
            dTagVld <= 1'b0;
        end else if (dStall) begin
            dTag    <= aluRes[WORD_W-1:3];
            dTagVld <= 1'b1;
        end else if (!icacheHit) begin
            iTag    <= pcQ[WORD_W-1:3];
            iTagVld <= 1'b1;
            ifId    <= encode(OP_NOP, 3'd0, 3'd0, 6'd0);
        end else begin
            pcQ  <= pcQ + WORD_W'(1);
            ifId <= romWord;
        end
    end

    always_ff @(posedge clk) begin
        if (regWrite) begin
            regFile[rd] <= writeData;
        end
        if (memWrite) begin
            dataMem[aluRes[2:0]] <= rdVal;
        end
    end

endmodule

// File: rtl/stat_counter.sv
// Wrapping statistics counter: counts cycles where en is high and freeze is low.
// Latency: 1 cycle from event to visible count.
// Backpressure: none; freeze holds the value.
module stat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         freeze,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (en && !freeze) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/proc_hier_top.sv
// Core wrapper exposing commit/memory probes and cycle, retirement and cache statistics.
// Latency: probes combinational; counters and halted lag their events by one cycle.
// Backpressure: none; counters freeze once a HALT has been observed until reset.
module proc_hier_top
    import proc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [WORD_W-1:0]    pc,
    output logic [WORD_W-1:0]    inst,
    output logic                 reg_write,
    output logic [REG_IDX_W-1:0] write_register,
    output logic [WORD_W-1:0]    write_data,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_W-1:0]    mem_address,
    output logic [WORD_W-1:0]    mem_data_in,
    output logic [WORD_W-1:0]    mem_data_out,
    output logic                 icache_req,
    output logic                 icache_hit,
    output logic                 dcache_req,
    output logic                 dcache_hit,
    output logic                 halt,
    output logic                 halted,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [CNT_W-1:0]     inst_count,
    output logic [CNT_W-1:0]     icache_hit_count,
    output logic [CNT_W-1:0]     icache_req_count,
    output logic [CNT_W-1:0]     dcache_hit_count,
    output logic [CNT_W-1:0]     dcache_req_count
);

    logic coreRegWrite, coreMemWrite, coreHalt;
    logic coreICacheReq, coreICacheHit, coreDCacheReq, coreDCacheHit;

    proc p0 (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .inst          (inst),
        .regWrite      (coreRegWrite),
        .writeRegister (write_register),
        .writeData     (write_data),
        .memRead       (mem_read),
        .memWrite      (coreMemWrite),
        .memAddress    (mem_address),
        .memDataIn     (mem_data_in),
        .memDataOut    (mem_data_out),
        .icacheReq     (coreICacheReq),
        .icacheHit     (coreICacheHit),
        .dcacheReq     (coreDCacheReq),
        .dcacheHit     (coreDCacheHit),
        .halt          (coreHalt)
    );

    assign reg_write  = coreRegWrite;
    assign mem_write  = coreMemWrite;
    assign halt       = coreHalt;
    assign icache_req = coreICacheReq;
    assign icache_hit = coreICacheHit;
    assign dcache_req = coreDCacheReq;
    assign dcache_hit = coreDCacheHit;

    // halted is registered, so the HALT cycle itself still gets its final increment.
    always_ff @(posedge clk) begin
        if (!rst) begin
            halted <= 1'b0;
        end else if (coreHalt) begin
            halted <= 1'b1;
        end
    end

    stat_counter #(.W(CNT_W)) uCycle (
        .clk(clk), .rst(rst), .en(1'b1), .freeze(halted), .count(cycle_count)
    );

    stat_counter #(.W(CNT_W)) uInst (
        .clk(clk), .rst(rst), .en(retireEvent(coreHalt, coreRegWrite, coreMemWrite)),
        .freeze(halted), .count(inst_count)
    );

    stat_counter #(.W(CNT_W)) uICacheHit (
        .clk(clk), .rst(rst), .en(coreICacheHit), .freeze(halted), .count(icache_hit_count)
    );

    stat_counter #(.W(CNT_W)) uICacheReq (
        .clk(clk), .rst(rst), .en(coreICacheReq), .freeze(halted), .count(icache_req_count)
    );

    stat_counter #(.W(CNT_W)) uDCacheHit (
        .clk(clk), .rst(rst), .en(coreDCacheHit), .freeze(halted), .count(dcache_hit_count)
    );

    stat_counter #(.W(CNT_W)) uDCacheReq (
        .clk(clk), .rst(rst), .en(coreDCacheReq), .freeze(halted), .count(dcache_req_count)
    );

endmodule

// File: tb/tb_proc_hier_top.sv
// Directed + randomized bench for proc_hier_top; core event strobes are overridden
// so the statistics layer can be driven against a plain-arithmetic reference model.
module tb_proc_hier_top;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] pc, inst, write_data, mem_address, mem_data_in, mem_data_out;
    logic [2:0]  write_register;
    logic        reg_write, mem_read, mem_write;
    logic        icache_req, icache_hit, dcache_req, dcache_hit, halt, halted;
    logic [31:0] cycle_count, inst_count;
    logic [31:0] icache_hit_count, icache_req_count, dcache_hit_count, dcache_req_count;

    proc_hier_top #(.CNT_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc               (pc),
        .inst             (inst),
        .reg_write        (reg_write),
        .write_register   (write_register),
        .write_data       (write_data),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_address      (mem_address),
        .mem_data_in      (mem_data_in),
        .mem_data_out     (mem_data_out),
        .icache_req       (icache_req),
        .icache_hit       (icache_hit),
        .dcache_req       (dcache_req),
        .dcache_hit       (dcache_hit),
        .halt             (halt),
        .halted           (halted),
        .cycle_count      (cycle_count),
        .inst_count       (inst_count),
        .icache_hit_count (icache_hit_count),
        .icache_req_count (icache_req_count),
        .dcache_hit_count (dcache_hit_count),
        .dcache_req_count (dcache_req_count)
    );

    always #5 clk = ~clk;

    int nPass  = 0;
    int nTotal = 0;

    // Reference model: statistics as plain numbers.
    logic [31:0] mCyc, mInst, mIReq, mIHit, mDReq, mDHit;
    logic        mHalted;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTotal++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic checkAll();
        chk("cycle_count", cycle_count, mCyc);
        chk("inst_count", inst_count, mInst);
        chk("icache_req_count", icache_req_count, mIReq);
        chk("icache_hit_count", icache_hit_count, mIHit);
        chk("dcache_req_count", dcache_req_count, mDReq);
        chk("dcache_hit_count", dcache_hit_count, mDHit);
        chk("halted", {31'd0, halted}, {31'd0, mHalted});
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic r, input logic h, input logic rw, input logic mw,
                        input logic ir, input logic ih, input logic dr, input logic dh);
        rst = r;
        if (h)  force dut.coreHalt      = 1'b1; else force dut.coreHalt      = 1'b0;
        if (rw) force dut.coreRegWrite  = 1'b1; else force dut.coreRegWrite  = 1'b0;
        if (mw) force dut.coreMemWrite  = 1'b1; else force dut.coreMemWrite  = 1'b0;
        if (ir) force dut.coreICacheReq = 1'b1; else force dut.coreICacheReq = 1'b0;
        if (ih) force dut.coreICacheHit = 1'b1; else force dut.coreICacheHit = 1'b0;
        if (dr) force dut.coreDCacheReq = 1'b1; else force dut.coreDCacheReq = 1'b0;
        if (dh) force dut.coreDCacheHit = 1'b1; else force dut.coreDCacheHit = 1'b0;
        #1;
        chk("probe_halt", {31'd0, halt}, {31'd0, h});
        chk("probe_reg_write", {31'd0, reg_write}, {31'd0, rw});
        chk("probe_mem_write", {31'd0, mem_write}, {31'd0, mw});
        chk("probe_icache_req", {31'd0, icache_req}, {31'd0, ir});
        chk("probe_dcache_hit", {31'd0, dcache_hit}, {31'd0, dh});
        @(posedge clk);
        if (!r) begin
            mCyc = 0; mInst = 0; mIReq = 0; mIHit = 0; mDReq = 0; mDHit = 0; mHalted = 1'b0;
        end else if (!mHalted) begin
            mCyc  = mCyc + 1;
            mInst = mInst + ((h || rw || mw) ? 32'd1 : 32'd0);
            mIReq = mIReq + 32'(ir);
            mIHit = mIHit + 32'(ih);
            mDReq = mDReq + 32'(dr);
            mDHit = mDHit + 32'(dh);
            mHalted = h;
        end
        @(negedge clk);
        checkAll();
    endtask

    task automatic randStep(input logic allowHalt);
        logic [6:0] rv;
        logic       h;
        rv = 7'($urandom);
        h  = allowHalt && ($urandom_range(0, 15) == 0);
        step(1'b1, h, rv[0], rv[1], rv[2], rv[3], rv[4], rv[5]);
    endtask

    initial begin
        logic [7:0] hitPat;
        mCyc = 0; mInst = 0; mIReq = 0; mIHit = 0; mDReq = 0; mDHit = 0; mHalted = 1'b0;
        @(negedge clk);

        // Reset held with every event asserted: nothing may count.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("reset_cycle_zero", cycle_count, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("first_cycle", cycle_count, 32'd1);

        // Simultaneous register and memory writes retire one instruction per cycle.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("dual_retire", inst_count, 32'd10);

        // Cache counters, including a data hit with no request.
        hitPat = 8'b1011_0101;
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, hitPat[i], 1'b0, (i == 3));
        chk("icache_req_8", icache_req_count, 32'd8);
        chk("icache_hit_5", icache_hit_count, 32'd5);
        chk("dcache_hit_noreq", dcache_hit_count, 32'd1);
        chk("dcache_req_none", dcache_req_count, 32'd0);

        for (int i = 0; i < 40; i++) randStep(1'b0);

        // HALT in cycle 20 after seven retirements.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 19; i++) begin
            if (i <= 7) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            else        step(1'b1, 1'b0, 1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("halt_inst", inst_count, 32'd8);
        chk("halt_cycle", cycle_count, 32'd20);
        chk("halt_flag", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'($urandom), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("frozen_inst", inst_count, 32'd8);
        chk("frozen_cycle", cycle_count, 32'd20);

        // Reset after halt clears everything and counting resumes.
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("post_halt_reset", {31'd0, halted}, 32'd0);
        for (int i = 0; i < 30; i++) randStep(1'b1);

        // Cycle counter wrap.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        force dut.uCycle.count = 32'hFFFF_FFFF;
        #1;
        release dut.uCycle.count;
        mCyc = 32'hFFFF_FFFF;
        chk("preload", cycle_count, 32'hFFFF_FFFF);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("cycle_wrap", cycle_count, 32'h0000_0000);

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule

// File: doc/proc_hier_top.md
# proc_hier_top

Top-level processor hierarchy wrapper. Instantiates the processor core (`p0`) and owns the architectural trace/statistics layer. That layer consists of:
- a free-running cycle counter;
- retired-instruction and cache request/hit counters;
- a sticky halt flag;
- a flat, registered-free probe bundle that exposes the core's commit-stage and memory-stage activity to simulation monitors and FPGA debug.

## Interface
Parameters:
- `CNT_W`, default 32: width of every statistics counter.

Ports (clock and reset first):
- `clk`, in, 1: single system clock; all state updates on rising edge.
- `rst`, in, 1: reset; **one clock; reset is synchronous and active-low**.
- `pc`, out, 16: fetch-stage PC of the core.
- `inst`, out, 16: instruction held in the fetch/decode pipeline register.
- `reg_write`, out, 1: register file written this cycle (commit, not stalled).
- `write_register`, out, 3: destination register index.
- `write_data`, out, 16: write-back data.
- `mem_read`, out, 1: data memory read performed this cycle.
- `mem_write`, out, 1: data memory write performed this cycle.
- `mem_address`, out, 16: data memory address (ALU result).
- `mem_data_in`, out, 16: store data.
- `mem_data_out`, out, 16: load data.
- `icache_req`, out, 1: valid instruction-cache request.
- `icache_hit`, out, 1: instruction-cache hit.
- `dcache_req`, out, 1: valid data-cache request.
- `dcache_hit`, out, 1: data-cache hit.
- `halt`, out, 1: HALT in memory/write-back stage this cycle.
- `halted`, out, 1: sticky; set once `halt` is seen.
- `cycle_count`, out, CNT_W: cycles since reset release.
- `inst_count`, out, CNT_W: retired instructions.
- `icache_hit_count`, `icache_req_count`, `dcache_hit_count`, `dcache_req_count`, out, CNT_W each: cache statistics.

## Operation
- Probe outputs are combinational pass-throughs of the corresponding core outputs.
- Gating: `reg_write`, `mem_read` and `mem_write` are the core's "real" (stall-qualified) versions.
- Retirement event: `halt | reg_write | mem_write`. Each cycle with the event true increments `inst_count` by 1.
- Each cache counter increments by 1 in any cycle where its signal is 1.
- Hit and req are counted independently; a hit without a req still counts.
- `cycle_count` increments every non-reset, non-halted cycle.
- Halt cycle:
  - counters perform their final increment, including `inst_count` for the HALT itself;
  - `halted` sets;
  - from the next cycle on, all counters freeze.
- Counters wrap modulo 2^CNT_W with no saturation and no flag.
- `halted` clears only via reset. The core keeps running after halt; freezing affects only this block's counters.

## Timing
- While `rst`=0 at a rising edge, all counters and `halted` become 0 at that edge, and events in that cycle are not counted.
- Reset mid-run (after halt or otherwise) clears everything identically.
- Counter values reflect events up to and including the previous cycle, i.e. 1-cycle latency.
- Probe outputs have zero latency.
- Simultaneous events (e.g. `reg_write` and `mem_write` in one cycle) increment `inst_count` by exactly 1.

## Structure
- Shared package `proc_pkg`: `CNT_W` default, 16-bit word width, 3-bit register index width, retirement-event definition.
- Sub-module: `proc`, the existing core. Instantiated as `p0`; its probe outputs are wired one-to-one.
- A single counter sub-module `stat_counter`, taking (en, freeze), is natural and is instantiated 6×.
- No other hierarchy.

## Test plan
- Reset hold 3 cycles with all events forced 1 → all counters 0, `halted`=0. Release → `cycle_count`=1 after first edge.
- 10 cycles with `reg_write`=1 and `mem_write`=1 simultaneously → `inst_count`=10, not 20.
- `icache_req`=1 for 8 cycles, `icache_hit`=1 on 5 of them; `dcache_hit`=1 once with `dcache_req`=0 → counts 8, 5, and `dcache_hit_count`=1.
- `halt` pulse at cycle 20 after 7 prior retirements → `inst_count`=8, `cycle_count`=20, `halted`=1. Further events for 10 cycles → values unchanged.
- Reset asserted after halt → all counters 0, `halted`=0, counting resumes on release.
- Preload `cycle_count` to 0xFFFFFFFF via a force, then 1 cycle → 0x00000000.
